// File: rtl/dmem_pkg.sv
// Shared types and widths for the multi-cycle data-memory responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmem_pkg;

    localparam int WORD_W    = 32;
    localparam int LAT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } op_t;

endpackage

// File: rtl/dmem_responder_if.sv
// CPU <-> data-memory request/response bundle.
// Latency: n/a (wires only).
// Backpressure: the responder holds the CPU with stall_o until ack_o.
// master = CPU side (drives MemRead_i/MemWrite_i/addr_i/data_i).
// slave  = memory side (drives data_o/stall_o/ack_o/err_o).
interface dmem_responder_if;
    import dmem_pkg::*;

    logic              MemRead_i;
    logic              MemWrite_i;
    logic [WORD_W-1:0] addr_i;
    logic [WORD_W-1:0] data_i;
    logic [WORD_W-1:0] data_o;
    logic              stall_o;
    logic              ack_o;
    logic              err_o;

    modport master (
        output MemRead_i, MemWrite_i, addr_i, data_i,
        input  data_o, stall_o, ack_o, err_o
    );

    modport slave (
        input  MemRead_i, MemWrite_i, addr_i, data_i,
        output data_o, stall_o, ack_o, err_o
    );

endinterface

// File: rtl/dmem_responder_array.sv
// Single-port word RAM, DEPTH x 32, synchronous write and registered read.
// Latency: rdata reflects mem[idx] one clock after idx is presented.
// Backpressure: none; accepts an access every cycle.
// Ports: clk_i, we (write enable), idx (word index), wdata, rdata.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              we,
    input  logic [ADDR_W-1:0] idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Contents are intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        rdata <= mem[idx];
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: latches a CPU request, waits LATENCY cycles, acks once.
// Latency: request seen in cycle 0 -> ack_o in cycle LATENCY; stall_o high for LATENCY cycles.
// Backpressure: stall_o holds the CPU from request until the single-cycle DONE (ack_o) state.
// Ports: clk_i, rst_i (async, active-high), bus (slave side of dmem_responder_if).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    dmem_responder_if.slave   bus
);

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("dmem_responder: LATENCY must be within 1..15");
        end
        if (DEPTH != (1 << ADDR_W)) begin : g_bad_depth
            $error("dmem_responder: DEPTH must equal 2**ADDR_W");
        end
    endgenerate

    // BUSY spends LATENCY-1 cycles (counter runs CNT_INIT..0), IDLE and DONE one each.
    localparam logic [LAT_CNT_W-1:0] CNT_INIT =
        (LATENCY > 1) ? LAT_CNT_W'(LATENCY - 2) : '0;

    state_t              state_q, state_d;
    logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
    op_t                 op_q;
    logic                err_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [WORD_W-1:0]   wdat_q;
    logic [WORD_W-1:0]   hold_q;

    logic                req;
    logic                req_err;
    logic [ADDR_W-1:0]   req_idx;

    logic                ram_we;
    logic [ADDR_W-1:0]   ram_idx;
    logic [WORD_W-1:0]   ram_rdata;
    logic [WORD_W-1:0]   data_out;
    logic                stall;
    logic                ack;
    logic                err;

    assign req     = bus.MemRead_i | bus.MemWrite_i;
    assign req_idx = bus.addr_i[ADDR_W+1:2];
    assign req_err = (bus.MemRead_i & bus.MemWrite_i)
                   | (bus.addr_i[1:0] != 2'b00)
                   | (bus.addr_i[WORD_W-1:ADDR_W+2] != '0);

    dmem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk_i (clk_i),
        .we    (ram_we),
        .idx   (ram_idx),
        .wdata (wdat_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_RD;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdat_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && req) begin
                op_q   <= bus.MemWrite_i ? OP_WR : OP_RD;
                err_q  <= req_err;
                idx_q  <= req_idx;
                wdat_q <= bus.data_i;
            end
            // Remember what DONE presented so data_o is stable between completions.
            if (state_q == DONE) begin
                hold_q <= data_out;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall    = 1'b0;
        ack      = 1'b0;
        err      = 1'b0;
        ram_we   = 1'b0;
        ram_idx  = idx_q;
        data_out = hold_q;

        case (state_q)
            IDLE: begin
                // Address the RAM from the live bus so a LATENCY==1 read has its
                // data registered on the IDLE->DONE edge.
                ram_idx = req_idx;
                if (req) begin
                    stall = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - LAT_CNT_W'(1);
                end
            end
            DONE: begin
                ack     = 1'b1;
                err     = err_q;
                state_d = IDLE;
                if (err_q) begin
                    data_out = '0;
                end else if (op_q == OP_RD) begin
                    data_out = ram_rdata;
                end else begin
                    ram_we = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.data_o  = data_out;
    assign bus.stall_o = stall;
    assign bus.ack_o   = ack;
    assign bus.err_o   = err;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance at LATENCY=3, one at LATENCY=1.
// Latency: n/a.
// Backpressure: n/a.
module tb_dmem_responder;

    logic clk;
    logic rst;

    logic [1:0]       rd_v;
    logic [1:0]       wr_v;
    logic [1:0][31:0] addr_v;
    logic [1:0][31:0] dat_v;

    logic [1:0]       ack_w;
    logic [1:0]       stall_w;
    logic [1:0]       err_w;
    logic [1:0][31:0] data_w;

    dmem_responder_if if3 ();
    dmem_responder_if if1 ();

    dmem_responder #(.DEPTH(256), .ADDR_W(8), .LATENCY(3)) u_dut3 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if3)
    );

    dmem_responder #(.DEPTH(256), .ADDR_W(8), .LATENCY(1)) u_dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if1)
    );

    assign if3.MemRead_i  = rd_v[0];
    assign if3.MemWrite_i = wr_v[0];
    assign if3.addr_i     = addr_v[0];
    assign if3.data_i     = dat_v[0];
    assign if1.MemRead_i  = rd_v[1];
    assign if1.MemWrite_i = wr_v[1];
    assign if1.addr_i     = addr_v[1];
    assign if1.data_i     = dat_v[1];

    assign ack_w   = {if1.ack_o,   if3.ack_o};
    assign stall_w = {if1.stall_o, if3.stall_o};
    assign err_w   = {if1.err_o,   if3.err_o};
    assign data_w  = {if1.data_o,  if3.data_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          d;
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdat;
        bit          exp_err;
        logic [31:0] exp_rd;
        bit          scramble;
        bit          keep;
        string       name;
    } vec_t;

    typedef struct {
        int          lat;
        bit          err;
        logic [31:0] dat;
        string       name;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[$];
    int          lat_of [2];
    logic [31:0] last_dat [2];
    int          checks;
    int          errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int d, input bit rd, input bit wr,
                                input logic [31:0] addr, input logic [31:0] wdat,
                                input bit exp_err, input logic [31:0] exp_rd,
                                input bit scramble, input bit keep, input string name);
        vec_t v;
        v.d = d; v.rd = rd; v.wr = wr; v.addr = addr; v.wdat = wdat;
        v.exp_err = exp_err; v.exp_rd = exp_rd; v.scramble = scramble;
        v.keep = keep; v.name = name;
        return v;
    endfunction

    // Called just after a rising edge; the request is present from this cycle (cycle 0).
    task automatic run_vec(input vec_t v);
        exp_t e;
        int   cyc;
        int   stalls;
        bit   seen;
        e.lat  = lat_of[v.d];
        e.err  = v.exp_err;
        e.name = v.name;
        e.dat  = v.exp_err ? 32'h0 : (v.rd ? v.exp_rd : last_dat[v.d]);
        sb.push_back(e);

        rd_v[v.d]   = v.rd;
        wr_v[v.d]   = v.wr;
        addr_v[v.d] = v.addr;
        dat_v[v.d]  = v.wdat;

        stalls = 0;
        seen   = 1'b0;
        for (cyc = 0; cyc < 40; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk);
                #1;
                if (v.scramble && cyc == 1) begin
                    addr_v[v.d] = v.addr ^ 32'h0000_0405;
                    dat_v[v.d]  = ~v.wdat;
                end
            end
            @(negedge clk);
            if (cyc == 0) begin
                check({v.name, ".hold"}, data_w[v.d], last_dat[v.d]);
            end
            if (ack_w[v.d]) begin
                seen = 1'b1;
                break;
            end
            if (stall_w[v.d]) stalls++;
        end

        e = sb.pop_front();
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s.timeout: no ack_o within 40 cycles, expected in cycle %0d", e.name, e.lat);
        end else begin
            check({e.name, ".ack_cycle"}, 32'(cyc), 32'(e.lat));
            check({e.name, ".stall_cnt"}, 32'(stalls), 32'(e.lat));
            check({e.name, ".stall_done"}, 32'(stall_w[v.d]), 32'h0);
            check({e.name, ".err"}, 32'(err_w[v.d]), 32'(e.err));
            check({e.name, ".data"}, data_w[v.d], e.dat);
            last_dat[v.d] = e.dat;
        end

        @(posedge clk);
        #1;
        if (!v.keep) begin
            rd_v[v.d] = 1'b0;
            wr_v[v.d] = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        checks = 0;
        errors = 0;
        lat_of[0] = 3;
        lat_of[1] = 1;
        last_dat[0] = 32'h0;
        last_dat[1] = 32'h0;

        //          dut rd wr addr          wdata         err exp_rd        scr keep name
        vecs.push_back(mk(0, 1, 0, 32'h0000_0010, 32'h0,         0, 32'hDEAD_BEEF, 0, 0, "pre_rd_skip"));
        vecs.delete();
        vecs.push_back(mk(0, 0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0,         0, 0, "wr_10"));
        vecs.push_back(mk(0, 1, 0, 32'h0000_0010, 32'h0,         0, 32'hDEAD_BEEF, 0, 0, "rd_10"));
        vecs.push_back(mk(0, 0, 1, 32'h0000_0013, 32'h1234_5678, 1, 32'h0,         0, 0, "wr_misalign"));
        vecs.push_back(mk(0, 1, 0, 32'h0000_0010, 32'h0,         0, 32'hDEAD_BEEF, 0, 0, "rd_10_after_mis"));
        vecs.push_back(mk(0, 0, 1, 32'h0000_0400, 32'h5555_5555, 1, 32'h0,         0, 0, "wr_oor"));
        vecs.push_back(mk(0, 1, 0, 32'h0000_0400, 32'h0,         1, 32'h0,         0, 0, "rd_oor"));
        vecs.push_back(mk(0, 1, 1, 32'h0000_0010, 32'h0BAD_F00D, 1, 32'h0,         0, 0, "rd_and_wr"));
        vecs.push_back(mk(0, 1, 0, 32'h0000_0010, 32'h0,         0, 32'hDEAD_BEEF, 0, 0, "rd_10_after_both"));
        vecs.push_back(mk(0, 0, 1, 32'h0000_03FC, 32'hA5A5_A5A5, 0, 32'h0,         0, 0, "wr_top"));
        vecs.push_back(mk(0, 1, 0, 32'h0000_03FC, 32'h0,         0, 32'hA5A5_A5A5, 0, 0, "rd_top"));
        vecs.push_back(mk(0, 0, 1, 32'h0000_0030, 32'h7777_8888, 0, 32'h0,         1, 0, "wr_30_scramble"));
        vecs.push_back(mk(0, 1, 0, 32'h0000_0030, 32'h0,         0, 32'h7777_8888, 0, 0, "rd_30"));
        vecs.push_back(mk(0, 1, 0, 32'h0000_0010, 32'h0,         0, 32'hDEAD_BEEF, 1, 0, "rd_10_scramble"));
        vecs.push_back(mk(0, 0, 1, 32'h0000_0020, 32'h1111_2222, 0, 32'h0,         0, 0, "wr_20"));
        vecs.push_back(mk(1, 0, 1, 32'h0000_0000, 32'h0101_0101, 0, 32'h0,         0, 0, "l1_wr_0"));
        vecs.push_back(mk(1, 0, 1, 32'h0000_0004, 32'h0202_0202, 0, 32'h0,         0, 0, "l1_wr_4"));
        vecs.push_back(mk(1, 1, 0, 32'h0000_0000, 32'h0,         0, 32'h0101_0101, 0, 1, "l1_rd_0_b2b"));
        vecs.push_back(mk(1, 1, 0, 32'h0000_0004, 32'h0,         0, 32'h0202_0202, 0, 0, "l1_rd_4_b2b"));
        vecs.push_back(mk(1, 1, 0, 32'h0000_0003, 32'h0,         1, 32'h0,         0, 0, "l1_rd_misalign"));

        rst    = 1'b1;
        rd_v   = '0;
        wr_v   = '0;
        addr_v = '0;
        dat_v  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset.data%0d", d),  data_w[d], 32'h0);
            check($sformatf("reset.ack%0d", d),   32'(ack_w[d]), 32'h0);
            check($sformatf("reset.err%0d", d),   32'(err_w[d]), 32'h0);
            check($sformatf("reset.stall%0d", d), 32'(stall_w[d]), 32'h0);
        end
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i]);
            if (!vecs[i].keep) begin
                @(posedge clk);
                #1;
            end
        end

        // Reset during BUSY of a write: must abort with no ack and no RAM update.
        wr_v[0]   = 1'b1;
        addr_v[0] = 32'h0000_0020;
        dat_v[0]  = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        check("abort.stall_busy", 32'(stall_w[0]), 32'h1);
        rst     = 1'b1;
        wr_v[0] = 1'b0;
        #1;
        check("abort.data", data_w[0], 32'h0);
        check("abort.ack",  32'(ack_w[0]), 32'h0);
        check("abort.err",  32'(err_w[0]), 32'h0);
        check("abort.stall", 32'(stall_w[0]), 32'h0);
        acks = 0;
        repeat (2) begin
            @(negedge clk);
            if (ack_w[0]) acks++;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_dat[0] = 32'h0;
        last_dat[1] = 32'h0;
        repeat (4) begin
            @(negedge clk);
            if (ack_w[0]) acks++;
        end
        check("abort.no_ack", 32'(acks), 32'h0);
        @(posedge clk);
        #1;
        run_vec(mk(0, 1, 0, 32'h0000_0020, 32'h0, 0, 32'h1111_2222, 0, 0, "rd_20_after_abort"));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
